// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types and helpers for the playfield matrix memory
package tetris_pkg;

  // Controller state: sweeping rows to zero, or serving ports A/B
  typedef enum bit [0:0] {eCLEAR, eREADY} mm_state_e;

  // Row address width for a given number of rows (never narrower than 1 bit)
  function automatic int row_addr_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/row_popcount.sv
// rtl/row_popcount.sv - combinational count of all-ones rows in a flattened array
module row_popcount #(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic [height_p*width_p-1:0]     rows_i,
  output logic [$clog2(height_p+1)-1:0]   count_o
);

  localparam int count_width_lp = $clog2(height_p + 1);

  // Walk every row and count the ones whose cells are all set
  always_comb begin
    count_o = '0;
    for (int r = 0; r < height_p; r++) begin
      if (&rows_i[r*width_p +: width_p]) begin
        count_o = count_o + count_width_lp'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_mem.sv
// rtl/matrix_mem.sv - playfield bit matrix with clear sweep, two read ports and full-row count (option MATRIX_MEM_WRITE_FWD_EN)
module matrix_mem
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32,
  localparam int addr_width_lp  = row_addr_width(height_p),
  localparam int count_width_lp = $clog2(height_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clear_v_i,
  output logic                      ready_o,
  input  logic [addr_width_lp-1:0]  mm_read_addr_i,
  output logic [width_p-1:0]        mm_read_data_o,
  input  logic [addr_width_lp-1:0]  mm_write_addr_i,
  input  logic [width_p-1:0]        mm_write_data_i,
  input  logic                      mm_write_v_i,
  input  logic [addr_width_lp-1:0]  rd_addr_i,
  output logic [width_p-1:0]        rd_data_o,
  output logic [count_width_lp-1:0] full_count_o
);

  localparam logic [addr_width_lp-1:0] last_row_lp = addr_width_lp'(height_p - 1);

  mm_state_e                 state_q;
  logic [addr_width_lp-1:0]  clear_row_q;
  logic [count_width_lp-1:0] full_count_q;
  logic [width_p-1:0]        mem_q [height_p];

  logic                      ready;
  logic                      wr_accept;
  logic [height_p*width_p-1:0] rows_flat;
  logic [count_width_lp-1:0] full_rows;

  // Row addresses above the last row are legal on the wires but map to nothing
  function automatic logic addr_ok(input logic [addr_width_lp-1:0] a);
    return 32'(a) < 32'(height_p);
  endfunction

  assign ready     = (state_q == eREADY);
  assign ready_o   = ready;
  assign wr_accept = mm_write_v_i && ready && addr_ok(mm_write_addr_i);

  // Read-before-write: ports see the stored row, zero when idle-clearing or out of range
  assign mm_read_data_o = (ready && addr_ok(mm_read_addr_i)) ? mem_q[mm_read_addr_i] : '0;

`ifdef MATRIX_MEM_WRITE_FWD_EN
  // Renderer port sees an accepted write to its row in the same cycle
  assign rd_data_o = (wr_accept && (rd_addr_i == mm_write_addr_i)) ? mm_write_data_i :
                     (ready && addr_ok(rd_addr_i)) ? mem_q[rd_addr_i] : '0;
`else
  assign rd_data_o = (ready && addr_ok(rd_addr_i)) ? mem_q[rd_addr_i] : '0;
`endif

  // Flatten the array so the popcount block sees every row at once
  for (genvar r = 0; r < height_p; r++) begin : g_flat
    assign rows_flat[r*width_p +: width_p] = mem_q[r];
  end

  row_popcount #(
    .width_p  (width_p),
    .height_p (height_p)
  ) u_row_popcount (
    .rows_i  (rows_flat),
    .count_o (full_rows)
  );

  assign full_count_o = full_count_q;

  // Sweep controller and full-row count register; a clear request zeroes the count at once
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= eCLEAR;
      clear_row_q  <= '0;
      full_count_q <= '0;
    end else begin
      full_count_q <= (ready && !clear_v_i) ? full_rows : '0;
      case (state_q)
        eCLEAR: begin
          if (clear_v_i) begin
            clear_row_q <= '0;
          end else if (clear_row_q == last_row_lp) begin
            clear_row_q <= '0;
            state_q     <= eREADY;
          end else begin
            clear_row_q <= clear_row_q + addr_width_lp'(1);
          end
        end
        eREADY: begin
          if (clear_v_i) begin
            clear_row_q <= '0;
            state_q     <= eCLEAR;
          end
        end
        default: begin
          state_q     <= eCLEAR;
          clear_row_q <= '0;
        end
      endcase
    end
  end

  // Array storage: the sweep owns the write port while clearing, port A otherwise
  always_ff @(posedge clk_i) begin
    if (state_q == eCLEAR) begin
      mem_q[clear_row_q] <= '0;
    end else if (wr_accept) begin
      mem_q[mm_write_addr_i] <= mm_write_data_i;
    end
  end

endmodule
